// File: rtl/iir_bank_if.sv
// Sample, coefficient and result signals of the iir_bank filter bank.
// The master is the producer/consumer side; the slave is the bank itself.
interface iir_bank_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         cfg_we;
  logic [3:0]   cfg_ch;
  logic [1:0]   cfg_sel;
  logic [31:0]  cfg_data;
  logic         out_valid;
  logic [3:0]   out_ch;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data,
    output cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  in_ready,
    input  out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_data,
    input  cfg_we, cfg_ch, cfg_sel, cfg_data,
    output in_ready,
    output out_valid, out_ch, out_data
  );
endinterface

// File: rtl/iir_bank.sv
// Time-multiplexed first-order IIR bank: NCH channels share one MAC and
// filter the same sample stream with per-channel sign-magnitude coefficients.
module iir_bank #(
  parameter int W     = 32,
  parameter int NCH   = 2,
  parameter int FRAC  = 16,
  parameter int AW    = 15,
  parameter int DEPTH = 32768
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  iir_bank_if.slave     bus,
  output logic [AW-1:0] src_addr
);
  localparam int ACCW  = W + 34;
  localparam int PW    = W + 32;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSLOT = 1 << CW;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             ch_q, ch_d;
  logic signed [W-1:0]    x_q, x_d;
  logic signed [W-1:0]    x1_q, x1_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [W-1:0]           od_q, od_d;
  logic [3:0]             oc_q, oc_d;
  logic signed [W-1:0]    y1_q [NSLOT];
  logic signed [W-1:0]    y1_d [NSLOT];
  logic [31:0]            a1_q [NSLOT];
  logic [31:0]            a1_d [NSLOT];
  logic [31:0]            b0_q [NSLOT];
  logic [31:0]            b0_d [NSLOT];
  logic [31:0]            b1_q [NSLOT];
  logic [31:0]            b1_d [NSLOT];

  logic [CW-1:0]          idx;
  logic [CW-1:0]          cidx;
  logic signed [31:0]     coef;
  logic signed [W-1:0]    opnd;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] sh;
  logic [W-1:0]           sat;
  logic                   rdy;
  logic                   ov;
  logic                   accept;

  function automatic logic signed [31:0] sm2tc(logic [31:0] c);
    logic signed [31:0] m;
    m = $signed({1'b0, c[30:0]});
    return c[31] ? -m : m;
  endfunction

  assign idx  = ch_q[CW-1:0];
  assign cidx = bus.cfg_ch[CW-1:0];
  assign sh   = acc_q >>> FRAC;
  // Result fits only when all bits above the W-bit sign agree with it.
  assign sat  = (&sh[ACCW-1:W-1] || ~|sh[ACCW-1:W-1]) ? sh[W-1:0]
              : (sh[ACCW-1] ? MINV : MAXV);

  assign rdy    = rst && (state_q == IDLE);
  assign accept = bus.in_valid && rdy && !clr;

  always_comb begin
    coef = sm2tc(b0_q[idx]);
    opnd = x_q;
    unique case (state_q)
      MAC1: begin
        coef = sm2tc(b1_q[idx]);
        opnd = x1_q;
      end
      MAC2: begin
        coef = sm2tc(a1_q[idx]);
        opnd = y1_q[idx];
      end
      default: ;
    endcase
    prod = PW'(coef) * PW'(opnd);
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    x_d     = x_q;
    x1_d    = x1_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    od_d    = od_q;
    oc_d    = oc_q;
    y1_d    = y1_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    ov      = 1'b0;

    if (bus.cfg_we && rdy && int'({28'd0, bus.cfg_ch}) < NCH) begin
      unique case (bus.cfg_sel)
        2'd0:    a1_d[cidx] = bus.cfg_data;
        2'd1:    b0_d[cidx] = bus.cfg_data;
        2'd2:    b1_d[cidx] = bus.cfg_data;
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = bus.in_data;
          acc_d   = '0;
          ch_d    = '0;
          addr_d  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          state_d = MAC0;
        end
      end
      MAC0: begin
        acc_d   = acc_q + ACCW'(prod);
        state_d = MAC1;
      end
      MAC1: begin
        acc_d   = acc_q + ACCW'(prod);
        state_d = MAC2;
      end
      MAC2: begin
        acc_d   = acc_q - ACCW'(prod);
        state_d = OUT;
      end
      OUT: begin
        ov        = 1'b1;
        od_d      = sat;
        oc_d      = ch_q;
        y1_d[idx] = sat;
        acc_d     = '0;
        if (ch_q != 4'(NCH - 1)) begin
          ch_d    = ch_q + 1'b1;
          state_d = MAC0;
        end else begin
          x1_d    = x_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear drops only filter history; coefficients and address survive.
    if (clr) begin
      state_d = IDLE;
      x1_d    = '0;
      ov      = 1'b0;
      od_d    = od_q;
      oc_d    = oc_q;
      for (int i = 0; i < NSLOT; i++) y1_d[i] = '0;
    end
    if (!rst) ov = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      od_q    <= '0;
      oc_q    <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        y1_q[i] <= '0;
        a1_q[i] <= '0;
        b0_q[i] <= '0;
        b1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
      y1_q    <= y1_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  assign src_addr     = addr_q;
  assign bus.in_ready = rdy;
  assign bus.out_valid = ov;
  assign bus.out_ch   = ov ? ch_q : oc_q;
  assign bus.out_data = ov ? sat : od_q;
endmodule

// File: tb/tb_iir_bank.sv
// Bench for iir_bank: vector table plus scoreboard of expected results,
// with hand-written sequences for latency, clear and address wrap.
module tb_iir_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [14:0] src_addr;
  int          checks = 0;
  int          fails  = 0;
  int          ea     = 0;

  iir_bank_if #(.W(32)) bus ();

  iir_bank #(
    .W(32), .NCH(2), .FRAC(16), .AW(15), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bus(bus),
    .src_addr(src_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit          c;
    bit          wr;
    logic [3:0]  ch;
    logic [1:0]  sel;
    logic [31:0] d;
    bit          smp;
    logic [31:0] x;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic cfg_wr(logic [3:0] ch, logic [1:0] sel, logic [31:0] d);
    wait_ready();
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = ch;
    bus.cfg_sel  = sel;
    bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic clr_pulse();
    wait_ready();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send(logic [31:0] x, logic [31:0] e0, logic [31:0] e1);
    wait_ready();
    q.push_back('{4'd0, e0});
    q.push_back('{4'd1, e1});
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    tick();
    bus.in_valid = 1'b0;
    ea = (ea + 1) % 4;
    @(negedge clk);
    chk("src_addr", 64'(src_addr), 64'(ea));
    tick();
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_ch", 64'(bus.out_ch), 64'(e.ch));
        chk("out_data", 64'(bus.out_data), 64'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 1, 4'd1, 2'd1, 32'h80000000, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 4'd2, 2'd1, 32'h00050000, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 4'd0, 2'd3, 32'h00070000, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 4'd0, 2'd0, 32'h80008000, 1, 64, 64, 0};
    tbl[4]  = '{0, 0, 4'd0, 2'd0, 0, 1, 0, 32, 0};
    tbl[5]  = '{0, 0, 4'd0, 2'd0, 0, 1, 0, 16, 0};
    tbl[6]  = '{0, 1, 4'd0, 2'd2, 32'h80010000, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 4'd0, 2'd0, 0, 1, 10, 10, 0};
    tbl[8]  = '{0, 0, 4'd0, 2'd0, 0, 1, 10, 0, 0};
    tbl[9]  = '{0, 0, 4'd0, 2'd0, 0, 1, 32'hFFFFFFFB, 32'hFFFFFFF1, 0};
    tbl[10] = '{0, 1, 4'd0, 2'd2, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 4'd0, 2'd1, 32'h7FFFFFFF, 1,
                32'h00100000, 32'h7FFFFFFF, 0};
    tbl[12] = '{1, 0, 4'd0, 2'd0, 0, 1, 32'hFFF00000, 32'h80000000, 0};

    rst = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_sel  = '0;
    bus.cfg_data = '0;

    // reset
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_src_addr", 64'(src_addr), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(bus.in_ready), 1);
    tick();
    send(100, 0, 0);

    // pass-through and latency
    cfg_wr(4'd0, 2'd1, 32'h00010000);
    cfg_wr(4'd1, 2'd1, 32'h00020000);
    wait_ready();
    q.push_back('{4'd0, 32'd100});
    q.push_back('{4'd1, 32'd200});
    q.push_back('{4'd0, 32'd100});
    q.push_back('{4'd1, 32'd200});
    bus.in_valid = 1'b1;
    bus.in_data  = 100;
    @(negedge clk);
    chk("lat_ready_c0", 64'(bus.in_ready), 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      @(negedge clk);
      chk("lat_out_valid", 64'(bus.out_valid), 64'(c == 4 || c == 8));
      chk("lat_in_ready", 64'(bus.in_ready), 64'(c == 9));
      chk("lat_no_accept", 64'(src_addr), 64'((ea + 1) % 4));
    end
    tick();
    bus.in_valid = 1'b0;
    ea = (ea + 2) % 4;
    @(negedge clk);
    chk("lat_src_addr", 64'(src_addr), 64'(ea));
    tick();

    // recursion, feedforward, ignored writes, saturation
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].c) clr_pulse();
      if (tbl[i].wr) cfg_wr(tbl[i].ch, tbl[i].sel, tbl[i].d);
      if (tbl[i].smp) send(tbl[i].x, tbl[i].e0, tbl[i].e1);
    end

    // clear mid-sample and dropped write while busy
    cfg_wr(4'd0, 2'd1, 32'h00010000);
    cfg_wr(4'd0, 2'd0, 32'h80008000);
    clr_pulse();
    send(40, 40, 0);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = 1000;
    tick();
    ea = (ea + 1) % 4;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 4'd0;
    bus.cfg_sel  = 2'd1;
    bus.cfg_data = 32'h00030000;
    @(negedge clk);
    chk("busy_in_ready", 64'(bus.in_ready), 0);
    tick();
    bus.cfg_we = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", 64'(bus.out_valid), 0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 64'(bus.in_ready), 1);
    for (int c = 0; c < 4; c++) begin
      chk("clr_no_out", 64'(bus.out_valid), 0);
      tick();
      @(negedge clk);
    end
    tick();
    send(20, 20, 0);

    // address wrap
    wait_ready();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    ea = 0;
    for (int i = 0; i < 6; i++) send(32'(i * 7 + 1), 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      chk("addr_hold", 64'(src_addr), 2);
    end
    tick();

    wait_ready();
    repeat (3) tick();
    chk("queue_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/iir_bank.md
Name: iir_bank

Overview:
- Time-multiplexed first-order IIR filter bank: NCH channels share one multiply-accumulate datapath and all filter the same input stream.
- Each channel has its own runtime-writable sign-magnitude coefficients, so one instance replaces fixed per-filter instances such as a low-pass and high-pass pair.
- Adds a valid/ready input handshake, a wrap-limited sample-source address generator, output saturation, and a history-only clear.
- Sits between the sample ROM and downstream consumers.

Parameters:
- W, 32: data width of input and output samples, signed two's complement.
- NCH, 2: number of channels, 1..16.
- FRAC, 16: fractional bits of the coefficient magnitude.
- AW, 15: width of the source address.
- DEPTH, 32768: source length; the address wraps after DEPTH-1. Range 2..2^AW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- clr  in  1  synchronous, active-high clear of filter history.
- in_valid  in  1  input sample valid.
- in_data  in  W  input sample x[n].
- in_ready  out  1  bank idle; a sample is accepted when in_valid and in_ready are both high.
- src_addr  out  AW  address of the next source sample.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  4  channel index for the write.
- cfg_sel  in  2  coefficient select: 0=a1, 1=b0, 2=b1, 3=ignored.
- cfg_data  in  32  coefficient; bit31 is the sign, bits30:0 are the magnitude with FRAC fractional bits.
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  4  channel of the result.
- out_data  out  W  result y[n].

Behaviour:
- Filter equation per channel: y[n] = b0*x[n] + b1*x[n-1] - a1*y[n-1].
- x[n-1] is a single shared register; y[n-1] is held per channel.
- Coefficients are converted from sign-magnitude to two's complement before multiplying. Negative zero equals zero.
- Products are full precision and summed in an accumulator of W+34 bits.
- Result = accumulator arithmetically shifted right by FRAC (floor, no rounding), then saturated to signed W: above 2^(W-1)-1 gives 0x7FF..F; below -2^(W-1) gives 0x800..0.
- The saturated value is both the output and the stored y[n-1].
- FSM states: IDLE, MAC0 (b0*x), MAC1 (b1*x1), MAC2 (a1*y1), OUT. A channel counter ch runs 0..NCH-1.
- IDLE: in_ready=1. On accept, capture in_data, clear the accumulator, set ch=0, go to MAC0.
- MAC0 -> MAC1 -> MAC2 -> OUT, one cycle each.
- OUT: out_valid=1, out_ch=ch, out_data=result; y1[ch] is updated. If ch<NCH-1, increment ch and go to MAC0. Otherwise load x1 with x and go to IDLE.
- Timing: with the accept cycle as cycle 0, channel c is output in cycle 4c+4. in_ready returns in cycle 4*NCH+1, so the peak rate is one sample per 4*NCH+1 cycles.
- out_data and out_ch hold their last values while out_valid=0.
- src_addr: increments on each accept; DEPTH-1 wraps to 0.
- Coefficient writes take effect only when in_ready=1, landing on the next edge. Writes while busy are dropped. cfg_ch >= NCH and cfg_sel=3 are ignored.
- clr=1: abort any sample in progress and go to IDLE; zero x1 and all y1; out_valid=0 in that cycle.
  - Coefficients and src_addr are retained.
  - A sample offered in the same cycle as clr is not accepted.
  - A coefficient write in that cycle is still applied if in_ready=1.
- rst=0: everything is zeroed, including coefficients, src_addr, out_valid, out_data and out_ch. State goes to IDLE. rst has priority over clr.
- in_ready is 0 during reset and 1 from the first cycle after release.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> out_valid=0, out_data=0, src_addr=0, in_ready=0. After release -> in_ready=1; a sample x=100 with all coefficients zero -> ch0 and ch1 both output 0.
- Pass-through and latency: ch0 b0=0x00010000, ch1 b0=0x00020000, accept x=100 in cycle 0 -> cycle 4 gives out_ch=0, out_data=100; cycle 8 gives out_ch=1, out_data=200. in_ready=1 in cycle 9, and no accept occurs before it.
- Recursion and feedforward: ch0 b0=0x00010000, a1=0x80008000 (-0.5); x=64,0,0 -> 64,32,16. Then set b1=0x80010000 and a1=0. Feed x=10,10,-5 -> outputs 10, 0, -15.
- Saturation: ch0 b0=0x7FFFFFFF, x=0x00100000 -> out_data=0x7FFFFFFF. x=0xFFF00000 (history cleared first) -> out_data=0x80000000.
- Clear mid-sample and dropped write:
  - Pulse clr in cycle 2 after an accept -> no out_valid; in_ready=1 next cycle.
  - Next sample's result excludes the old history, and the coefficients are unchanged.
  - A cfg write issued in cycle 1 is dropped.
- Address wrap: DEPTH=4, accept 6 samples -> src_addr after each accept reads 1,2,3,0,1,2. src_addr does not move while in_valid=0.
